// File: rtl/stm_mod_mixer_pkg.sv
// Shared types and helpers for stm_mod_mixer.
// The optional STM_MOD_MIXER_BYPASS_EN macro is consumed by the interface and top.
package stm_mod_mixer_pkg;

    localparam int unsigned MIXER_LATENCY = 3;

    typedef enum logic {
        IDLE,
        RUN
    } mixer_state_t;

    // floor(p/255) for p = I*M with 8-bit I, M, without a divider
    function automatic logic [7:0] div255(input logic [15:0] p);
        logic [16:0] s;
        s = {1'b0, p} + {9'd0, p[15:8]} + 17'd1;
        return 8'(s >> 8);
    endfunction

endpackage

// File: rtl/stm_mod_mixer_if.sv
// Beat/control bundle between the STM source and stm_mod_mixer.
// BYPASS exists only when STM_MOD_MIXER_BYPASS_EN is defined.
interface stm_mod_mixer_if #(parameter int unsigned IDX_W = 8);
    logic             START;
    logic [7:0]       MOD_VALUE;
    logic [7:0]       INTENSITY_IN;
    logic [7:0]       PHASE_IN;
    logic             DIN_VALID;
    logic             ERR_CLR;
`ifdef STM_MOD_MIXER_BYPASS_EN
    logic             BYPASS;
`endif
    logic [7:0]       INTENSITY_OUT;
    logic [7:0]       PHASE_OUT;
    logic             DOUT_VALID;
    logic [IDX_W-1:0] IDX_OUT;
    logic             BURST_DONE;
    logic             ERR_OVERRUN;
    logic             ERR_STRAY;

    modport master (
`ifdef STM_MOD_MIXER_BYPASS_EN
        output BYPASS,
`endif
        output START, MOD_VALUE, INTENSITY_IN, PHASE_IN, DIN_VALID, ERR_CLR,
        input  INTENSITY_OUT, PHASE_OUT, DOUT_VALID, IDX_OUT, BURST_DONE,
        input  ERR_OVERRUN, ERR_STRAY
    );

    modport slave (
`ifdef STM_MOD_MIXER_BYPASS_EN
        input  BYPASS,
`endif
        input  START, MOD_VALUE, INTENSITY_IN, PHASE_IN, DIN_VALID, ERR_CLR,
        output INTENSITY_OUT, PHASE_OUT, DOUT_VALID, IDX_OUT, BURST_DONE,
        output ERR_OVERRUN, ERR_STRAY
    );
endinterface

// File: rtl/stm_mod_mixer_div255.sv
// Two-stage pipelined (I*M)/255 unit with valid and sideband passthrough.
// Data registers hold their last value while no beat is moving.
module mixer_div255
    import stm_mod_mixer_pkg::*;
#(
    parameter int unsigned SIDE_W = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [7:0]        i_int,
    input  logic [7:0]        i_mod,
    input  logic              i_bypass,
    input  logic [SIDE_W-1:0] i_side,
    output logic              o_valid,
    output logic [7:0]        o_int,
    output logic [SIDE_W-1:0] o_side
);

    logic              r_s2_valid;
    logic              r_s2_bypass;
    logic [15:0]       r_s2_prod;
    logic [7:0]        r_s2_raw;
    logic [SIDE_W-1:0] r_s2_side;
    logic [7:0]        w_quot;

    always_comb w_quot = div255(r_s2_prod);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_bypass <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_raw    <= '0;
            r_s2_side   <= '0;
            o_valid     <= 1'b0;
            o_int       <= '0;
            o_side      <= '0;
        end else begin
            r_s2_valid <= i_valid;
            if (i_valid) begin
                r_s2_prod   <= {8'd0, i_int} * {8'd0, i_mod};
                r_s2_raw    <= i_int;
                r_s2_bypass <= i_bypass;
                r_s2_side   <= i_side;
            end
            o_valid <= r_s2_valid;
            if (r_s2_valid) begin
                o_int  <= r_s2_bypass ? r_s2_raw : w_quot;
                o_side <= r_s2_side;
            end
        end
    end

endmodule

// File: rtl/stm_mod_mixer.sv
// STM modulation mixer: burst framing, error flags and S1 capture; S2-S3 in mixer_div255.
// Optional STM_MOD_MIXER_BYPASS_EN adds a per-beat BYPASS of the multiply.
module stm_mod_mixer
    import stm_mod_mixer_pkg::*;
#(
    parameter int unsigned DEPTH = 249,
    parameter int unsigned IDX_W = 8
) (
    input logic           CLK,
    input logic           RST_N,
    stm_mod_mixer_if.slave bus
);

    localparam int unsigned SIDE_W = 8 + IDX_W + 1;

    mixer_state_t     r_state;
    logic [IDX_W-1:0] r_count;
    logic [7:0]       r_mod;
    logic             r_err_overrun;
    logic             r_err_stray;

    logic             r_s1_valid;
    logic [7:0]       r_s1_int;
    logic [7:0]       r_s1_phase;
    logic [IDX_W-1:0] r_s1_idx;
    logic [7:0]       r_s1_mod;
    logic             r_s1_last;
    logic             r_s1_bypass;

    logic              w_accept;
    logic              w_last;
    logic              w_overrun;
    logic              w_stray;
    logic              w_bypass;
    logic              w_dout_valid;
    logic [7:0]        w_dout_int;
    logic [SIDE_W-1:0] w_side;

`ifdef STM_MOD_MIXER_BYPASS_EN
    assign w_bypass = bus.BYPASS;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_accept  = (r_state == RUN) && bus.DIN_VALID;
    assign w_last    = (r_count == IDX_W'(DEPTH - 1));
    // START on the closing beat of a burst is a clean back-to-back, not an overrun
    assign w_overrun = (r_state == RUN) && bus.START && (r_count != '0) && !(w_accept && w_last);
    assign w_stray   = (r_state == IDLE) && bus.DIN_VALID;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_mod         <= '0;
            r_err_overrun <= 1'b0;
            r_err_stray   <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_int      <= '0;
            r_s1_phase    <= '0;
            r_s1_idx      <= '0;
            r_s1_mod      <= '0;
            r_s1_last     <= 1'b0;
            r_s1_bypass   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_int    <= bus.INTENSITY_IN;
                r_s1_phase  <= bus.PHASE_IN;
                r_s1_idx    <= r_count;
                r_s1_mod    <= r_mod;
                r_s1_last   <= w_last;
                r_s1_bypass <= w_bypass;
            end

            if (bus.START) begin
                r_state <= RUN;
                r_mod   <= bus.MOD_VALUE;
                r_count <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            r_err_overrun <= w_overrun | (r_err_overrun & ~bus.ERR_CLR);
            r_err_stray   <= w_stray   | (r_err_stray   & ~bus.ERR_CLR);
        end
    end

    mixer_div255 #(.SIDE_W(SIDE_W)) u_div (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_valid  (r_s1_valid),
        .i_int    (r_s1_int),
        .i_mod    (r_s1_mod),
        .i_bypass (r_s1_bypass),
        .i_side   ({r_s1_phase, r_s1_idx, r_s1_last}),
        .o_valid  (w_dout_valid),
        .o_int    (w_dout_int),
        .o_side   (w_side)
    );

    assign bus.DOUT_VALID    = w_dout_valid;
    assign bus.INTENSITY_OUT = w_dout_int;
    assign bus.PHASE_OUT     = w_side[SIDE_W-1 -: 8];
    assign bus.IDX_OUT       = w_side[IDX_W:1];
    assign bus.BURST_DONE    = w_side[0] & w_dout_valid;
    assign bus.ERR_OVERRUN   = r_err_overrun;
    assign bus.ERR_STRAY     = r_err_stray;

endmodule
